button_conditioner: RTL



---
 rtl/alarm_clock_pkg.sv | 20 ++
 rtl/button_channel.sv | 118 +++++++++++
 rtl/button_conditioner.sv | 36 +++
 3 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: button channel indices and the
// per-channel auto-repeat state encoding.
package alarm_clock_pkg;

  localparam int BTN_SPARE        = 0;
  localparam int BTN_PLUS_HOUR    = 1;
  localparam int BTN_PLUS_MIN     = 2;
  localparam int BTN_SHOW_SECONDS = 3;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_DELAY,
    RS_REPEAT
  } rep_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchroniser, stable-count debounce,
// press strobe and optional hold-to-repeat strobe generation.
module button_channel
  import alarm_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_step_pulse
);

  localparam int TMR_MAX = imax(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_DELAY  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] TMR_PERIOD = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] TMR_ONE    = TW'(1);

  logic [1:0]    r_sync;
  logic [DW-1:0] r_db_cnt;
  logic          r_pressed;
  logic          r_press_pulse;
  logic          r_step_pulse;
  rep_state_t    r_state;
  logic [TW-1:0] r_tmr;

  logic          w_diff;
  logic          w_hit;
  logic          w_rise;
  logic          w_fall;
  rep_state_t    w_state_nxt;
  logic [TW-1:0] w_tmr_nxt;
  logic          w_rep;

  // Button is active-low; invert before synchronising so released reads 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], ~i_btn_n};
  end

  assign w_diff = (r_sync[1] != r_pressed);
  assign w_hit  = w_diff && (r_db_cnt == DB_LAST);
  assign w_rise = w_hit && !r_pressed;
  assign w_fall = w_hit &&  r_pressed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_db_cnt  <= '0;
      r_pressed <= 1'b0;
    end else if (!w_diff || w_hit) begin
      r_db_cnt  <= '0;
      r_pressed <= r_pressed ^ w_hit;
    end else begin
      r_db_cnt  <= r_db_cnt + DW'(1);
    end
  end

  // Timer is loaded on the edge pressed rises and fires a strobe on the edge
  // it would reach zero, so the first repeat lands REPEAT_DELAY cycles after
  // the press strobe. A release on that same edge suppresses the strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_rep       = 1'b0;
    case (r_state)
      RS_IDLE: begin
        if (REPEAT_EN && w_rise) begin
          w_state_nxt = RS_DELAY;
          w_tmr_nxt   = TMR_DELAY;
        end
      end
      RS_DELAY, RS_REPEAT: begin
        if (w_fall) begin
          w_state_nxt = RS_IDLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == TMR_ONE) begin
          w_state_nxt = RS_REPEAT;
          w_tmr_nxt   = TMR_PERIOD;
          w_rep       = 1'b1;
        end else begin
          w_tmr_nxt   = r_tmr - TMR_ONE;
        end
      end
      default: begin
        w_state_nxt = RS_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= RS_IDLE;
      r_tmr         <= '0;
      r_press_pulse <= 1'b0;
      r_step_pulse  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tmr         <= w_tmr_nxt;
      r_press_pulse <= w_rise;
      r_step_pulse  <= w_rise | w_rep;
    end
  end

  assign o_pressed     = r_pressed;
  assign o_press_pulse = r_press_pulse;
  assign o_step_pulse  = r_step_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Alarm-clock button front end: NUM_BUTTONS independent conditioned channels,
// auto-repeat enabled per channel by REPEAT_MASK.
module button_conditioner
  import alarm_clock_pkg::*;
#(
  parameter int                     NUM_BUTTONS     = 4,
  parameter int                     DEBOUNCE_CYCLES = 20,
  parameter int                     REPEAT_DELAY    = 1000,
  parameter int                     REPEAT_PERIOD   = 200,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = 4'b0110
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_n,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] step_pulse
);

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[gi])
    ) u_ch (
      .i_clk         (clk_in),
      .i_rst         (reset),
      .i_btn_n       (button_n[gi]),
      .o_pressed     (pressed[gi]),
      .o_press_pulse (press_pulse[gi]),
      .o_step_pulse  (step_pulse[gi])
    );
  end

endmodule
